// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store controller (dm_lsu_ctrl).
package dm_lsu_pkg;

    localparam int IDX_W_DEF = 6;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/dm_lane_mux.sv
// Lane steering for dm_lsu_ctrl: load extract with sign/zero extension, and
// store lane merge into a word read from memory.
module dm_lane_mux import dm_lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      byte_off,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{byte_off, 3'b000} +: 8];
    assign half_lane = rdata[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata;
        merged    = rdata;
        case (size)
            SZ_B: begin
                load_data = is_unsigned ? {{(XLEN-8){1'b0}}, byte_lane}
                                        : {{(XLEN-8){byte_lane[7]}}, byte_lane};
                merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = is_unsigned ? {{(XLEN-16){1'b0}}, half_lane}
                                        : {{(XLEN-16){half_lane[15]}}, half_lane};
                merged[{byte_off[1], 4'b0000} +: 16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_lsu_ctrl.sv
// MEM-stage load/store controller for a word-wide data memory; sub-word stores
// use a two-cycle read-modify-write. Define DM_LSU_DBG_EN to add a debug port.
module dm_lsu_ctrl import dm_lsu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic [XLEN-1:0]  mem_rdata,
    output logic             mem_stall,
    output logic             mem_misalign,
    output logic [XLEN-1:0]  dm_addr,
    output logic [XLEN-1:0]  dm_wdata,
    output logic             dm_we,
`ifdef DM_LSU_DBG_EN
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [IDX_W-1:0] dbg_idx,
    input  logic [XLEN-1:0]  dbg_wdata,
    output logic             dbg_gnt,
    output logic [XLEN-1:0]  dbg_rdata,
`endif
    input  logic [XLEN-1:0]  dm_rdata
);

    lsu_state_t       state_q, state_d;
    logic [XLEN-1:0]  merge_q, merge_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] req_idx, dm_idx;
    logic [XLEN-1:0]  load_data, merged;
    logic             is_word, misaligned;
    logic             unused_addr_hi;

    assign req_idx        = mem_addr[IDX_W+1:2];
    assign is_word        = mem_size[1];
    assign misaligned     = ((mem_size == SZ_H) && mem_addr[0]) ||
                            (is_word && (mem_addr[1:0] != 2'b00));
    assign dm_addr        = {{(XLEN-IDX_W){1'b0}}, dm_idx};
    assign unused_addr_hi = ^mem_addr[XLEN-1:IDX_W+2];

    dm_lane_mux #(.XLEN(XLEN)) u_lane_mux (
        .size        (mem_size),
        .byte_off    (mem_addr[1:0]),
        .is_unsigned (mem_unsigned),
        .rdata       (dm_rdata),
        .wdata       (mem_wdata[15:0]),
        .load_data   (load_data),
        .merged      (merged)
    );

`ifdef DM_LSU_DBG_EN
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
    assign dbg_rdata = dbg_rdata_q;
`endif

    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        idx_d        = idx_q;
        dm_idx       = req_idx;
        dm_wdata     = mem_wdata;
        dm_we        = 1'b0;
        mem_rdata    = '0;
        mem_stall    = 1'b0;
        mem_misalign = 1'b0;
`ifdef DM_LSU_DBG_EN
        dbg_gnt      = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
`endif
        // NOTE: outputs are forced quiet while rst is high, so a reset landing
        // in MERGE drops the pending write instead of waiting for the flops.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        if (misaligned) begin
                            mem_misalign = 1'b1;
                        end else if (!mem_we) begin
                            mem_rdata = load_data;
                        end else if (is_word) begin
                            dm_we = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                            merge_d   = merged;
                            idx_d     = req_idx;
                            state_d   = MERGE;
                        end
                    end
`ifdef DM_LSU_DBG_EN
                    else if (dbg_req) begin
                        dbg_gnt  = 1'b1;
                        dm_idx   = dbg_idx;
                        dm_wdata = dbg_wdata;
                        dm_we    = dbg_we;
                        if (!dbg_we) begin
                            dbg_rdata_d = dm_rdata;
                        end
                    end
`endif
                end
                MERGE: begin
                    dm_we    = 1'b1;
                    dm_wdata = merge_q;
                    dm_idx   = idx_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: all state updates are non-blocking so every flop samples the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DM_LSU_DBG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= dbg_rdata_d;
        end
    end
`endif

endmodule

// File: tb/tb_dm_lsu_ctrl.sv
// Directed bench for dm_lsu_ctrl with a 64-word behavioural data memory.
module tb_dm_lsu_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, mem_misalign;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;
`ifdef DM_LSU_DBG_EN
    logic        dbg_req, dbg_we, dbg_gnt;
    logic [5:0]  dbg_idx;
    logic [31:0] dbg_wdata, dbg_rdata;
`endif

    logic [31:0] mem [64];
    logic        init_all, tb_wr;
    logic [5:0]  tb_idx;
    logic [31:0] tb_dat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_we        (dm_we),
`ifdef DM_LSU_DBG_EN
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_idx      (dbg_idx),
        .dbg_wdata    (dbg_wdata),
        .dbg_gnt      (dbg_gnt),
        .dbg_rdata    (dbg_rdata),
`endif
        .dm_rdata     (dm_rdata)
    );

    // Data memory model: combinational read, posedge word write, plus bench preload.
    assign dm_rdata = mem[dm_addr[5:0]];

    always @(posedge clk) begin
        if (init_all) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd8;
        end else if (tb_wr) begin
            mem[tb_idx] <= tb_dat;
        end else if (dm_we) begin
            mem[dm_addr[5:0]] <= dm_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        mem_req      = req;
        mem_we       = we;
        mem_size     = sz;
        mem_unsigned = uns;
        mem_addr     = addr;
        mem_wdata    = wdata;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        tb_wr  = 1'b1;
        tb_idx = idx;
        tb_dat = val;
        tick();
        tb_wr  = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        init_all = 1'b1;
        tb_wr    = 1'b0;
        tb_idx   = '0;
        tb_dat   = '0;
`ifdef DM_LSU_DBG_EN
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_idx = '0; dbg_wdata = '0;
`endif
        drive(1'b1, 1'b1, W, 1'b0, 32'h10, 32'hFFFF_FFFF);
        tick();
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL rst_dm_we got=%b exp=0", dm_we); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
        drive(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", mem_rdata); end
        drive(1'b1, 1'b0, W, 1'b0, 32'h11, 32'h0);
        #1;
        checks++; if (mem_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", mem_misalign); end
        tick();
        init_all = 1'b0;
        rst      = 1'b0;
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_stall !== 1'b0 || dm_we !== 1'b0) begin failures++; $display("FAIL post_rst_idle stall=%b we=%b exp=0/0", mem_stall, dm_we); end
    endtask

    task automatic test_load_word();
        drive(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0000_0008) begin failures++; $display("FAIL lw_rdata got=%h exp=00000008", mem_rdata); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL lw_stall got=%b exp=0", mem_stall); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL lw_dm_we got=%b exp=0", dm_we); end
        checks++; if (dm_addr !== 32'd4) begin failures++; $display("FAIL lw_dm_addr got=%h exp=4", dm_addr); end
        tick();
    endtask

    task automatic test_sub_store();
        preload(6'd5, 32'h1122_3344);
        drive(1'b1, 1'b1, B, 1'b0, 32'h16, 32'h0000_00AB);
        #1;
        checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL sb_c0_stall got=%b exp=1", mem_stall); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL sb_c0_dm_we got=%b exp=0", dm_we); end
        tick();
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL sb_c1_dm_we got=%b exp=1", dm_we); end
        checks++; if (dm_addr !== 32'd5) begin failures++; $display("FAIL sb_c1_dm_addr got=%h exp=5", dm_addr); end
        checks++; if (dm_wdata !== 32'h11AB_3344) begin failures++; $display("FAIL sb_c1_wdata got=%h exp=11ab3344", dm_wdata); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL sb_c1_stall got=%b exp=0", mem_stall); end
        tick();
        checks++; if (mem[5] !== 32'h11AB_3344) begin failures++; $display("FAIL sb_mem5 got=%h exp=11ab3344", mem[5]); end
        drive(1'b1, 1'b0, B, 1'b1, 32'h16, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0000_00AB) begin failures++; $display("FAIL lbu_16 got=%h exp=000000ab", mem_rdata); end
        drive(1'b1, 1'b0, B, 1'b0, 32'h16, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'hFFFF_FFAB) begin failures++; $display("FAIL lb_16 got=%h exp=ffffffab", mem_rdata); end
        tick();
        // Upper-half store into word 6 (reset value 8).
        drive(1'b1, 1'b1, H, 1'b0, 32'h1A, 32'hFFFF_1234);
        tick();
        checks++; if (dm_wdata !== 32'h1234_0008 || dm_we !== 1'b1) begin failures++; $display("FAIL sh_1a got=%h we=%b exp=12340008 we=1", dm_wdata, dm_we); end
        tick();
    endtask

    task automatic test_half_load();
        preload(6'd2, 32'h8000_1234);
        drive(1'b1, 1'b0, H, 1'b0, 32'h0A, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'hFFFF_8000) begin failures++; $display("FAIL lh_0a got=%h exp=ffff8000", mem_rdata); end
        drive(1'b1, 1'b0, H, 1'b1, 32'h0A, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0000_8000) begin failures++; $display("FAIL lhu_0a got=%h exp=00008000", mem_rdata); end
        drive(1'b1, 1'b0, H, 1'b0, 32'h08, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0000_1234) begin failures++; $display("FAIL lh_08 got=%h exp=00001234", mem_rdata); end
        drive(1'b1, 1'b0, B, 1'b0, 32'h0B, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_0b got=%h exp=ffffff80", mem_rdata); end
        drive(1'b1, 1'b0, B, 1'b1, 32'h09, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h0000_0012) begin failures++; $display("FAIL lbu_09 got=%h exp=00000012", mem_rdata); end
        tick();
    endtask

    task automatic test_word_store();
        drive(1'b1, 1'b1, W, 1'b0, 32'h0C, 32'hCAFE_F00D);
        #1;
        checks++; if (dm_we !== 1'b1 || mem_stall !== 1'b0) begin failures++; $display("FAIL sw_0c we=%b stall=%b exp=1/0", dm_we, mem_stall); end
        checks++; if (dm_wdata !== 32'hCAFE_F00D || dm_addr !== 32'd3) begin failures++; $display("FAIL sw_0c_bus wdata=%h addr=%h exp=cafef00d/3", dm_wdata, dm_addr); end
        tick();
        drive(1'b1, 1'b0, W, 1'b0, 32'h0C, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw_0c got=%h exp=cafef00d", mem_rdata); end
        tick();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b1, W, 1'b0, 32'h21, 32'hDEAD_BEEF);
        #1;
        checks++; if (mem_misalign !== 1'b1) begin failures++; $display("FAIL sw_21_misalign got=%b exp=1", mem_misalign); end
        checks++; if (dm_we !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL sw_21_we_stall we=%b stall=%b exp=0/0", dm_we, mem_stall); end
        tick();
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_misalign !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle got=%b exp=0", mem_misalign); end
        checks++; if (mem[8] !== 32'd8) begin failures++; $display("FAIL sw_21_mem8 got=%h exp=8", mem[8]); end
        drive(1'b1, 1'b0, H, 1'b0, 32'h03, 32'h0);
        #1;
        checks++; if (mem_misalign !== 1'b1 || mem_rdata !== 32'h0) begin failures++; $display("FAIL lh_03 misalign=%b rdata=%h exp=1/0", mem_misalign, mem_rdata); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
        #1;
        checks++; if (mem_misalign !== 1'b1) begin failures++; $display("FAIL sz11_12 misalign=%b exp=1", mem_misalign); end
        drive(1'b1, 1'b0, H, 1'b1, 32'h00, 32'h0);
        #1;
        checks++; if (mem_misalign !== 1'b0 || mem_rdata !== 32'h8) begin failures++; $display("FAIL lhu_00 misalign=%b rdata=%h exp=0/8", mem_misalign, mem_rdata); end
        tick();
    endtask

    task automatic test_no_req();
        drive(1'b0, 1'b1, H, 1'b0, 32'h11, 32'h1234_5678);
        #1;
        checks++; if (dm_we !== 1'b0 || mem_stall !== 1'b0 || mem_rdata !== 32'h0 || mem_misalign !== 1'b0)
            begin failures++; $display("FAIL no_req we=%b stall=%b rdata=%h mis=%b exp=0/0/0/0", dm_we, mem_stall, mem_rdata, mem_misalign); end
        tick();
    endtask

    task automatic test_merge_reset();
        drive(1'b1, 1'b1, H, 1'b0, 32'h04, 32'h0000_BEEF);
        #1;
        checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL sh_04_stall got=%b exp=1", mem_stall); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL merge_rst_dm_we got=%b exp=0", dm_we); end
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_stall !== 1'b0 || dm_we !== 1'b0) begin failures++; $display("FAIL merge_rst_after stall=%b we=%b exp=0/0", mem_stall, dm_we); end
        checks++; if (mem[1] !== 32'd8) begin failures++; $display("FAIL merge_rst_mem1 got=%h exp=8", mem[1]); end
        drive(1'b1, 1'b0, W, 1'b0, 32'h04, 32'h0);
        #1;
        checks++; if (mem_rdata !== 32'h8 || dm_we !== 1'b0) begin failures++; $display("FAIL merge_rst_idle rdata=%h we=%b exp=8/0", mem_rdata, dm_we); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, B, 1'b0, 32'h28, 32'h0000_0011);
        tick();
        checks++; if (dm_wdata !== 32'h0000_0011 || dm_we !== 1'b1) begin failures++; $display("FAIL b2b_first wdata=%h we=%b exp=00000011/1", dm_wdata, dm_we); end
        tick();
        drive(1'b1, 1'b1, B, 1'b0, 32'h29, 32'h0000_0022);
        #1;
        checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL b2b_accept stall=%b exp=1", mem_stall); end
        tick();
        checks++; if (dm_wdata !== 32'h0000_2211 || dm_addr !== 32'd10) begin failures++; $display("FAIL b2b_second wdata=%h addr=%h exp=00002211/a", dm_wdata, dm_addr); end
        tick();
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem[10] !== 32'h0000_2211) begin failures++; $display("FAIL b2b_mem10 got=%h exp=00002211", mem[10]); end
    endtask

`ifdef DM_LSU_DBG_EN
    task automatic test_dbg();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_idx = 6'd3; dbg_wdata = 32'h55;
        drive(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0);
        #1;
        checks++; if (dbg_gnt !== 1'b0 || dm_we !== 1'b0) begin failures++; $display("FAIL dbg_blocked gnt=%b we=%b exp=0/0", dbg_gnt, dm_we); end
        tick();
        drive(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (dbg_gnt !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'd3) begin failures++; $display("FAIL dbg_wr gnt=%b we=%b addr=%h exp=1/1/3", dbg_gnt, dm_we, dm_addr); end
        tick();
        dbg_we = 1'b0;
        #1;
        checks++; if (dbg_gnt !== 1'b1 || dm_we !== 1'b0) begin failures++; $display("FAIL dbg_rd gnt=%b we=%b exp=1/0", dbg_gnt, dm_we); end
        tick();
        dbg_req = 1'b0;
        #1;
        checks++; if (dbg_rdata !== 32'h55) begin failures++; $display("FAIL dbg_rdata got=%h exp=55", dbg_rdata); end
        checks++; if (mem[3] !== 32'h55) begin failures++; $display("FAIL dbg_mem3 got=%h exp=55", mem[3]); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_word();
        test_sub_store();
        test_half_load();
        test_word_store();
        test_misalign();
        test_no_req();
        test_merge_reset();
        test_back_to_back();
`ifdef DM_LSU_DBG_EN
        test_dbg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
